// File: rtl/jk_bank_ctrl_pkg.sv
// Shared constants for the JK bank controller: opcodes, FSM state codes, requester ids.
package jk_ctrl_pkg;
  localparam int JK_WIDTH = 4;

  localparam logic [1:0] OP_HOLD   = 2'b00;
  localparam logic [1:0] OP_RESET  = 2'b01;
  localparam logic [1:0] OP_SET    = 2'b10;
  localparam logic [1:0] OP_TOGGLE = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_CHECK = 2'd2
  } state_e;

  localparam logic ID_A = 1'b0;
  localparam logic ID_B = 1'b1;
endpackage

// File: rtl/jk_bank_ctrl_if.sv
// Bundle of both requester handshakes plus the bank J/K/Q wires and completion report.
interface jk_bank_ctrl_if #(parameter int WIDTH = 4);
  logic             i_a_valid;
  logic             o_a_ready;
  logic [1:0]       i_a_op;
  logic [WIDTH-1:0] i_a_mask;
  logic             i_b_valid;
  logic             o_b_ready;
  logic [1:0]       i_b_op;
  logic [WIDTH-1:0] i_b_mask;
  logic [WIDTH-1:0] o_j;
  logic [WIDTH-1:0] o_k;
  logic [WIDTH-1:0] i_q;
  logic             o_done;
  logic             o_done_id;
  logic [WIDTH-1:0] o_q_snap;
  logic             o_err;

  modport master (
    output i_a_valid, i_a_op, i_a_mask, i_b_valid, i_b_op, i_b_mask, i_q,
    input  o_a_ready, o_b_ready, o_j, o_k, o_done, o_done_id, o_q_snap, o_err
  );

  modport slave (
    input  i_a_valid, i_a_op, i_a_mask, i_b_valid, i_b_op, i_b_mask, i_q,
    output o_a_ready, o_b_ready, o_j, o_k, o_done, o_done_id, o_q_snap, o_err
  );
endinterface

// File: rtl/jk_bank_ctrl_rr_arb2.sv
// Two-way round-robin arbiter; pointer remembers the last served requester and moves on advance.
module rr_arb2
  import jk_ctrl_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [1:0] i_req,
  input  logic       i_advance,
  output logic [1:0] o_grant
);
  logic r_last;

  // On contention the requester not served last wins; otherwise the lone requester.
  always_comb begin
    o_grant = i_req;
    if (i_req == 2'b11)
      o_grant = (r_last == ID_B) ? 2'b01 : 2'b10;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)       r_last <= ID_B;
    else if (i_advance) r_last <= o_grant[1];
  end
endmodule

// File: rtl/jk_bank_ctrl.sv
// Shares one JK flip-flop bank between requesters A and B: arbitrate, drive J/K one cycle, read Q back.
// Optional self-check of the bank result is enabled by defining JK_BANK_CTRL_VERIFY_EN.
module jk_bank_ctrl
  import jk_ctrl_pkg::*;
#(
  parameter int WIDTH = JK_WIDTH
) (
  input logic           i_clk,
  input logic           i_rst_n,
  jk_bank_ctrl_if.slave bus
);
  state_e           r_state;
  logic [WIDTH-1:0] r_j, r_k, r_snap;
  logic             r_done, r_id, r_sel_id;

  logic [1:0]       w_grant;
  logic             w_idle, w_a_ready, w_b_ready, w_hs;
  logic [1:0]       w_op;
  logic [WIDTH-1:0] w_mask;

  assign w_idle    = (r_state == ST_IDLE);
  assign w_a_ready = w_idle & w_grant[0] & bus.i_a_valid;
  assign w_b_ready = w_idle & w_grant[1] & bus.i_b_valid;
  assign w_hs      = w_a_ready | w_b_ready;
  assign w_op      = w_b_ready ? bus.i_b_op   : bus.i_a_op;
  assign w_mask    = w_b_ready ? bus.i_b_mask : bus.i_a_mask;

  rr_arb2 u_arb (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_req     ({bus.i_b_valid, bus.i_a_valid}),
    .i_advance (w_hs),
    .o_grant   (w_grant)
  );

  // J/K are decoded at handshake so they appear exactly in the DRIVE cycle and clear after it.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= ST_IDLE;
      r_j      <= '0;
      r_k      <= '0;
      r_snap   <= '0;
      r_done   <= 1'b0;
      r_id     <= 1'b0;
      r_sel_id <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_j    <= '0;
      r_k    <= '0;
      case (r_state)
        ST_IDLE: if (w_hs) begin
          r_j      <= w_mask & {WIDTH{w_op[1]}};
          r_k      <= w_mask & {WIDTH{w_op[0]}};
          r_sel_id <= w_b_ready ? ID_B : ID_A;
          r_state  <= ST_DRIVE;
        end
        ST_DRIVE: r_state <= ST_CHECK;
        ST_CHECK: begin
          r_snap  <= bus.i_q;
          r_done  <= 1'b1;
          r_id    <= r_sel_id;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef JK_BANK_CTRL_VERIFY_EN
  logic [WIDTH-1:0] r_exp;
  logic             r_err;

  function automatic logic [WIDTH-1:0] next_q(input logic [WIDTH-1:0] q,
                                              input logic [1:0] op,
                                              input logic [WIDTH-1:0] mask);
    case (op)
      OP_RESET:  return q & ~mask;
      OP_SET:    return q | mask;
      OP_TOGGLE: return q ^ mask;
      default:   return q;
    endcase
  endfunction

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_exp <= '0;
      r_err <= 1'b0;
    end else begin
      if (w_hs) r_exp <= next_q(bus.i_q, w_op, w_mask);
      if (r_state == ST_CHECK) r_err <= (bus.i_q != r_exp);
      else if (r_done)         r_err <= 1'b0;
    end
  end

  assign bus.o_err = r_err;
`else
  assign bus.o_err = 1'b0;
`endif

  assign bus.o_a_ready = w_a_ready;
  assign bus.o_b_ready = w_b_ready;
  assign bus.o_j       = r_j;
  assign bus.o_k       = r_k;
  assign bus.o_done    = r_done;
  assign bus.o_done_id = r_id;
  assign bus.o_q_snap  = r_snap;
endmodule

// File: tb/tb_jk_bank_ctrl.sv
// Directed bench for jk_bank_ctrl with a behavioural 4-bit JK bank on o_j/o_k/i_q.
module tb_jk_bank_ctrl;
  import jk_ctrl_pkg::*;

`ifdef JK_BANK_CTRL_VERIFY_EN
  localparam logic VERIFY = 1'b1;
`else
  localparam logic VERIFY = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  jk_bank_ctrl_if #(.WIDTH(4)) bus ();
  jk_bank_ctrl #(.WIDTH(4)) dut (.i_clk(clk), .i_rst_n(rst_n), .bus(bus));

  // Behavioural bank of four JK flip-flops; fault pins bit0 at 0.
  logic [3:0] q = 4'b0000;
  logic       fault = 1'b0;
  logic [3:0] w_nq;
  always_comb begin
    w_nq = q;
    for (int i = 0; i < 4; i++)
      case ({bus.o_j[i], bus.o_k[i]})
        2'b01:   w_nq[i] = 1'b0;
        2'b10:   w_nq[i] = 1'b1;
        2'b11:   w_nq[i] = ~q[i];
        default: w_nq[i] = q[i];
      endcase
    if (fault) w_nq[0] = 1'b0;
  end
  always_ff @(posedge clk) q <= w_nq;
  assign bus.i_q = q;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0] op;
    logic [3:0] mask;
    logic       flt;
    logic [3:0] jx;
    logic [3:0] kx;
    logic [3:0] snap;
    logic       err;
  } row_t;

  row_t rows[8];

  // One A command: wait for ready, then check DRIVE, CHECK and the completion cycle.
  task automatic run_a(input row_t r);
    int n;
    @(posedge clk); #1;
    bus.i_a_valid = 1'b1; bus.i_a_op = r.op; bus.i_a_mask = r.mask;
    n = 0;
    @(negedge clk);
    while (!bus.o_a_ready && n < 8) begin @(negedge clk); n++; end
    chk("a_ready", {31'b0, bus.o_a_ready}, 1);
    @(posedge clk); #1;
    bus.i_a_valid = 1'b0;
    @(negedge clk);
    chk("drive_j", {28'b0, bus.o_j}, {28'b0, r.jx});
    chk("drive_k", {28'b0, bus.o_k}, {28'b0, r.kx});
    @(negedge clk);
    chk("check_jk", {24'b0, bus.o_j, bus.o_k}, 0);
    chk("check_done", {31'b0, bus.o_done}, 0);
    @(negedge clk);
    chk("done", {31'b0, bus.o_done}, 1);
    chk("done_id", {31'b0, bus.o_done_id}, {31'b0, ID_A});
    chk("q_snap", {28'b0, bus.o_q_snap}, {28'b0, r.snap});
    chk("err", {31'b0, bus.o_err}, {31'b0, r.err});
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    rows[0] = '{OP_RESET,  4'hF,    1'b0, 4'h0,    4'hF,    4'h0,    1'b0};
    rows[1] = '{OP_SET,    4'b0101, 1'b0, 4'b0101, 4'h0,    4'b0101, 1'b0};
    rows[2] = '{OP_TOGGLE, 4'b0011, 1'b0, 4'b0011, 4'b0011, 4'b0110, 1'b0};
    rows[3] = '{OP_RESET,  4'b0101, 1'b0, 4'h0,    4'b0101, 4'b0010, 1'b0};
    rows[4] = '{OP_SET,    4'b1000, 1'b0, 4'b1000, 4'h0,    4'b1010, 1'b0};
    rows[5] = '{OP_HOLD,   4'hF,    1'b0, 4'h0,    4'h0,    4'b1010, 1'b0};
    rows[6] = '{OP_SET,    4'b0001, 1'b1, 4'b0001, 4'h0,    4'b1010, VERIFY};
    rows[7] = '{OP_TOGGLE, 4'h0,    1'b0, 4'h0,    4'h0,    4'b1010, 1'b0};

    rst_n = 1'b0;
    bus.i_a_valid = 1'b0; bus.i_a_op = 2'b00; bus.i_a_mask = 4'h0;
    bus.i_b_valid = 1'b0; bus.i_b_op = 2'b00; bus.i_b_mask = 4'h0;
    repeat (2) @(negedge clk);
    chk("rst_jk", {24'b0, bus.o_j, bus.o_k}, 0);
    chk("rst_outs", {25'b0, bus.o_done, bus.o_done_id, bus.o_err, bus.o_q_snap}, 0);
    chk("rst_ready", {30'b0, bus.o_a_ready, bus.o_b_ready}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      fault = rows[i].flt;
      run_a(rows[i]);
      fault = 1'b0;
    end

    // Reset asserted while the command is in DRIVE: it must vanish without a completion.
    @(posedge clk); #1;
    bus.i_a_valid = 1'b1; bus.i_a_op = OP_SET; bus.i_a_mask = 4'b0001;
    @(negedge clk);
    chk("mid_ready", {31'b0, bus.o_a_ready}, 1);
    @(posedge clk); #1;
    bus.i_a_valid = 1'b0;
    chk("mid_drive_j", {28'b0, bus.o_j}, 4'b0001);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_jk", {24'b0, bus.o_j, bus.o_k}, 0);
    chk("mid_rst_snap", {28'b0, bus.o_q_snap}, 0);
    chk("mid_rst_done", {31'b0, bus.o_done}, 0);
    chk("mid_rst_ready", {30'b0, bus.o_a_ready, bus.o_b_ready}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    begin
      logic seen = 1'b0;
      repeat (4) begin @(negedge clk); seen |= bus.o_done; end
      chk("mid_no_done", {31'b0, seen}, 0);
    end
    chk("mid_bank_q", {28'b0, q}, 4'b1010);

    // Contention right after reset: A wins, B is served next, then A wins again.
    @(posedge clk); #1;
    bus.i_a_valid = 1'b1; bus.i_a_op = OP_SET;   bus.i_a_mask = 4'b0100;
    bus.i_b_valid = 1'b1; bus.i_b_op = OP_RESET; bus.i_b_mask = 4'b0010;
    @(negedge clk);
    chk("c1_grant", {30'b0, bus.o_a_ready, bus.o_b_ready}, 2'b10);
    @(posedge clk); #1;
    bus.i_a_valid = 1'b0;
    @(negedge clk);
    chk("c1_drive_j", {28'b0, bus.o_j}, 4'b0100);
    chk("c1_b_wait", {31'b0, bus.o_b_ready}, 0);
    @(negedge clk);
    chk("c1_b_wait2", {31'b0, bus.o_b_ready}, 0);
    @(negedge clk);
    chk("c1_done", {31'b0, bus.o_done}, 1);
    chk("c1_id", {31'b0, bus.o_done_id}, 0);
    chk("c1_snap", {28'b0, bus.o_q_snap}, 4'b1110);
    chk("c2_b_ready", {31'b0, bus.o_b_ready}, 1);
    @(posedge clk); #1;
    bus.i_b_valid = 1'b0;
    @(negedge clk);
    chk("c2_pulse_end", {31'b0, bus.o_done}, 0);
    chk("c2_drive_k", {28'b0, bus.o_k}, 4'b0010);
    @(negedge clk);
    @(posedge clk); #1;
    bus.i_a_valid = 1'b1; bus.i_a_op = OP_HOLD; bus.i_a_mask = 4'h0;
    bus.i_b_valid = 1'b1; bus.i_b_op = OP_HOLD; bus.i_b_mask = 4'h0;
    @(negedge clk);
    chk("c2_done", {31'b0, bus.o_done}, 1);
    chk("c2_id", {31'b0, bus.o_done_id}, 1);
    chk("c2_snap", {28'b0, bus.o_q_snap}, 4'b1100);
    chk("c3_grant", {30'b0, bus.o_a_ready, bus.o_b_ready}, 2'b10);
    @(posedge clk); #1;
    bus.i_a_valid = 1'b0; bus.i_b_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("c3_done", {31'b0, bus.o_done}, 1);
    chk("c3_id", {31'b0, bus.o_done_id}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
